// File: rtl/bk_kbd_buffer.sv
// bk_kbd_buffer: buffers decoded BK key codes for the core's keyboard register,
// generates autorepeat codes while a key is held and drives the keydown level.
//
// Handshake: key_strobe/key_release are single-cycle pulses from the translator
// and are always accepted (no ready). The core sees kbd_available/kbd_data/
// kbd_ar2 as registered levels; an entry is consumed on the falling edge of
// read_kbd, so the data stays stable for the whole register access.
module bk_kbd_buffer #(
    parameter int DEPTH     = 8,
    parameter int DELAY_CYC = 25000000,
    parameter int RATE_CYC  = 2500000,
    parameter int REPEAT_EN = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_strobe,
    input  logic [7:0] key_code,
    input  logic       key_ar2,
    input  logic       key_release,
    input  logic       read_kbd,
    output logic       kbd_available,
    output logic [7:0] kbd_data,
    output logic       kbd_ar2,
    output logic       keydown,
    output logic       overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CWID = AW + 1;
    localparam int MAXC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
    localparam int CW   = $clog2(MAXC);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
    logic [CWID-1:0] count, count_next;
    logic            rd_q;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      rep_code;
    logic            rep_ar2;

    logic            pop, full, rep_push, push, accept;
    logic [8:0]      push_data, head_next;

    // Push/pop decisions and the head entry that will be visible next cycle
    always_comb begin
        pop       = rd_q & ~read_kbd & (count != '0);
        full      = (count == CWID'(DEPTH));
        // key_strobe restarts timing and key_release ends the hold, so either
        // one suppresses a repeat due in the same cycle.
        rep_push  = (state != IDLE) && (cnt == '0) && !key_strobe && !key_release
                    && (REPEAT_EN != 0);
        push      = key_strobe | rep_push;
        push_data = key_strobe ? {key_ar2, key_code} : {rep_ar2, rep_code};
        accept    = push & (~full | pop);

        count_next = count;
        if (accept && !pop) begin
            count_next = count + CWID'(1);
        end else if (!accept && pop) begin
            count_next = count - CWID'(1);
        end

        rd_ptr_next = pop ? (rd_ptr + AW'(1)) : rd_ptr;
        // The next head is the entry being written this cycle when the FIFO
        // (after any pop) would otherwise be empty; storage is bypassed then.
        head_next = (accept && (wr_ptr == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, read history and registered core-facing outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_q          <= 1'b0;
            kbd_available <= 1'b0;
            kbd_data      <= 8'h00;
            kbd_ar2       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            rd_q     <= read_kbd;
            count    <= count_next;
            rd_ptr   <= rd_ptr_next;
            overflow <= key_strobe & full & ~pop;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            kbd_available <= (count_next != '0);
            // When the FIFO drains, the last head stays visible as a stale code.
            if (count_next != '0) begin
                {kbd_ar2, kbd_data} <= head_next;
            end
        end
    end

    // Autorepeat FSM with a shared delay/rate down-counter; keydown registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rep_code <= 8'h00;
            rep_ar2  <= 1'b0;
            keydown  <= 1'b0;
        end else if (key_strobe) begin
            rep_code <= key_code;
            rep_ar2  <= key_ar2;
            cnt      <= CW'(DELAY_CYC - 1);
            state    <= DELAY;
            keydown  <= 1'b1;
        end else if (key_release && (state != IDLE)) begin
            state   <= IDLE;
            keydown <= 1'b0;
        end else if (state != IDLE) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else if (REPEAT_EN != 0) begin
                cnt   <= CW'(RATE_CYC - 1);
                state <= REPEAT;
            end
        end
    end

endmodule

// File: tb/tb_bk_kbd_buffer.sv
// tb_bk_kbd_buffer: scenario tasks plus a randomized run, checked against a
// time-based model of the keyboard buffer (queue of entries, repeat times
// computed from the strobe time).
module tb_bk_kbd_buffer;

    localparam int DEPTH     = 4;
    localparam int DELAY_CYC = 20;
    localparam int RATE_CYC  = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_ar2;
    logic       key_release;
    logic       read_kbd;
    logic       kbd_available;
    logic [7:0] kbd_data;
    logic       kbd_ar2;
    logic       keydown;
    logic       overflow;

    bk_kbd_buffer #(
        .DEPTH(DEPTH), .DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .key_strobe(key_strobe), .key_code(key_code), .key_ar2(key_ar2),
        .key_release(key_release), .read_kbd(read_kbd),
        .kbd_available(kbd_available), .kbd_data(kbd_data), .kbd_ar2(kbd_ar2),
        .keydown(keydown), .overflow(overflow)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard / reference model state
    logic [8:0] exp_q[$];
    logic [8:0] m_last;
    logic [8:0] m_rep;
    logic       m_held;
    logic       m_prev_rd;
    logic       m_ovf;
    int         m_t0;
    int         cyc;
    int         n_cmp;
    int         n_fail;
    int         ovf_seen;

    task automatic model_reset();
        exp_q.delete();
        m_last    = 9'h000;
        m_rep     = 9'h000;
        m_held    = 1'b0;
        m_prev_rd = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // One clock of stimulus; the model is advanced and all outputs compared.
    task automatic step(input logic s, input logic [7:0] code, input logic a2,
                        input logic rel, input logic rd);
        logic fire;
        logic pop;
        key_strobe  = s;
        key_code    = code;
        key_ar2     = a2;
        key_release = rel;
        read_kbd    = rd;
        pop  = m_prev_rd && !rd && (exp_q.size() != 0);
        fire = 1'b0;
        if (s) begin
            m_held = 1'b1;
            m_t0   = cyc;
            m_rep  = {a2, code};
        end else if (rel) begin
            m_held = 1'b0;
        end else if (m_held && (cyc - m_t0) >= DELAY_CYC &&
                     ((cyc - m_t0 - DELAY_CYC) % RATE_CYC) == 0) begin
            fire = 1'b1;
        end
        if (pop) void'(exp_q.pop_front());
        m_ovf = 1'b0;
        if (s || fire) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(s ? {a2, code} : m_rep);
            else if (s) m_ovf = 1'b1;
        end
        m_prev_rd = rd;
        cyc++;
        if (exp_q.size() != 0) m_last = exp_q[0];
        @(posedge clk);
        #1;
        n_cmp++;
        if (kbd_available !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL avail cyc=%0d got=%b exp=%b", cyc, kbd_available, exp_q.size() != 0);
        end
        n_cmp++;
        if ({kbd_ar2, kbd_data} !== m_last) begin
            n_fail++;
            $display("FAIL data cyc=%0d got=%h exp=%h", cyc, {kbd_ar2, kbd_data}, m_last);
        end
        n_cmp++;
        if (keydown !== m_held) begin
            n_fail++;
            $display("FAIL keydown cyc=%0d got=%b exp=%b", cyc, keydown, m_held);
        end
        n_cmp++;
        if (overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
        end
        if (overflow === 1'b1) ovf_seen++;
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, rd);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        n_cmp++;
        if (kbd_available !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout got=%b exp=0", kbd_available);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({kbd_available, kbd_ar2, kbd_data, keydown, overflow} !== 12'h000) begin
            n_fail++;
            $display("FAIL %s got=%b%b_%h_%b%b exp=all zero", name, kbd_available,
                     kbd_ar2, kbd_data, keydown, overflow);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_strobe = 1'b0; key_code = 8'h00; key_ar2 = 1'b0;
        key_release = 1'b0; read_kbd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_values");
        reset_n = 1'b1;
        idle(2, 1'b0);
    endtask

    task automatic test_single_key();
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({kbd_available, kbd_data} !== {1'b1, 8'h41}) begin
            n_fail++;
            $display("FAIL single_first got=%b/%h exp=1/41", kbd_available, kbd_data);
        end
        idle(3, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({kbd_available, kbd_data} !== {1'b0, 8'h41}) begin
            n_fail++;
            $display("FAIL single_pop got=%b/%h exp=0/41", kbd_available, kbd_data);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
    endtask

    task automatic test_overflow();
        ovf_seen = 0;
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'h31 + 8'(i), 1'(i % 2), 1'b0, 1'b0);
        n_cmp++;
        if (ovf_seen != 1) begin
            n_fail++;
            $display("FAIL overflow_count got=%0d exp=1", ovf_seen);
        end
        n_cmp++;
        if ({kbd_ar2, kbd_data} !== 9'h031) begin
            n_fail++;
            $display("FAIL overflow_head got=%h exp=031", {kbd_ar2, kbd_data});
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_autorepeat();
        step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        idle(26, 1'b0);
        n_cmp++;
        if (keydown !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_keydown got=%b exp=1", keydown);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (keydown !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_release got=%b exp=0", keydown);
        end
        idle(8, 1'b0);
        n_cmp++;
        if (exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL repeat_entries got=%0d exp=3", exp_q.size());
        end
        drain();
    endtask

    task automatic test_rekey();
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        idle(9, 1'b0);
        step(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
        idle(22, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0, (i == 3));
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_push got=%b exp=0", overflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();
        step(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (keydown !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_wins got=%b exp=1", keydown);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        idle(21, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        key_strobe = 1'b0; key_release = 1'b0; read_kbd = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(30, 1'b0);
        n_cmp++;
        if (kbd_available !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_repeat got=%b exp=0", kbd_available);
        end
    endtask

    task automatic test_random();
        logic rd;
        rd = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) rd = ~rd;
            step(($urandom_range(0, 11) == 0), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 17) == 0), rd);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drain();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        m_t0   = 0;
        ovf_seen = 0;
        test_reset();
        test_single_key();
        test_overflow();
        test_autorepeat();
        test_rekey();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
